axi_traffic_engine: RTL and testbench

//  Parametrised AXI burst traffic generator/checker driving the DDR controller's combined address channel (ATYPE selects write or read).

---
 rtl/axi_traffic_engine.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_axi_traffic_engine.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_traffic_engine.sv
// AXI burst traffic generator/checker for the DDR controller's combined
// address channel. Writes LFSR-patterned INCR bursts, reads them back and
// compares beat-by-beat, then reports error count, first failing location
// and the number of active cycles.
//
// Handshake semantics (all channels): a transfer happens on the rising edge
// where VALID and READY are both high. This block never drops a VALID it has
// raised, and never changes AADDR/ALEN/ATYPE/WDATA/WLAST while VALID is
// waiting for READY.
module axi_traffic_engine #(
  parameter int                DATA_W     = 256,
  parameter int                ADDR_W     = 32,
  parameter int                ID_W       = 8,
  parameter logic [ADDR_W-1:0] START_ADDR = 32'h00000000,
  parameter logic [ADDR_W-1:0] STOP_ADDR  = 32'h00100000
) (
  input  logic                axi_clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [1:0]          cfg_mode,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [7:0]          cfg_burst_len,
  input  logic [15:0]         cfg_num_bursts,
  input  logic [31:0]         cfg_seed,
  input  logic                i_pause,
  output logic [ID_W-1:0]     DDR_AID_0,
  output logic [ADDR_W-1:0]   DDR_AADDR_0,
  output logic [7:0]          DDR_ALEN_0,
  output logic [2:0]          DDR_ASIZE_0,
  output logic [1:0]          DDR_ABURST_0,
  output logic [1:0]          DDR_ALOCK_0,
  output logic                DDR_ATYPE_0,
  output logic                DDR_AVALID_0,
  input  logic                DDR_AREADY_0,
  output logic [ID_W-1:0]     DDR_WID_0,
  output logic [DATA_W-1:0]   DDR_WDATA_0,
  output logic [DATA_W/8-1:0] DDR_WSTRB_0,
  output logic                DDR_WLAST_0,
  output logic                DDR_WVALID_0,
  input  logic                DDR_WREADY_0,
  input  logic [ID_W-1:0]     DDR_RID_0,
  input  logic [DATA_W-1:0]   DDR_RDATA_0,
  input  logic [1:0]          DDR_RRESP_0,
  input  logic                DDR_RLAST_0,
  input  logic                DDR_RVALID_0,
  output logic                DDR_RREADY_0,
  input  logic [ID_W-1:0]     DDR_BID_0,
  input  logic [1:0]          DDR_BRESP_0,
  input  logic                DDR_BVALID_0,
  output logic                DDR_BREADY_0,
  output logic                o_busy,
  output logic                o_done,
  output logic [2:0]          o_state,
  output logic [15:0]         o_err_cnt,
  output logic [ADDR_W-1:0]   o_first_err_addr,
  output logic [7:0]          o_first_err_beat,
  output logic                o_resp_err,
  output logic [31:0]         o_cycle_cnt
);

  localparam int          NLANE      = DATA_W / 32;
  localparam int          BEAT_BYTES = DATA_W / 8;
  localparam logic [2:0]  ASIZE_VAL  = 3'($clog2(DATA_W / 8));
  localparam logic [31:0] LFSR_POLY  = 32'h80200003;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_W_ADDR = 3'd1,
    ST_W_DATA = 3'd2,
    ST_W_RESP = 3'd3,
    ST_R_ADDR = 3'd4,
    ST_R_DATA = 3'd5,
    ST_NEXT   = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  typedef logic [ADDR_W:0] addr_ext_t;

  state_t              state;
  logic [1:0]          mode_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [15:0]         nb_q;
  logic [15:0]         burst_cnt;
  logic [31:0]         lfsr;
  logic [31:0]         lfsr_snap;
  logic [7:0]          beat_cnt;
  logic                launch_pending;
  logic                avalid_q;
  logic                atype_q;
  logic                wvalid_q;
  logic                wlast_q;
  logic                bready_q;
  logic                rready_q;
  logic                busy_q;
  logic                done_q;
  logic [15:0]         err_cnt;
  logic                first_err_seen;
  logic [ADDR_W-1:0]   first_err_addr;
  logic [7:0]          first_err_beat;
  logic                resp_err;
  logic [31:0]         cycle_cnt;

  logic [31:0]         seed_eff;
  logic [31:0]         lfsr_next;
  logic [DATA_W-1:0]   exp_rdata;
  logic                beat_last;
  logic                write_first;
  logic                start_acc;
  addr_ext_t           burst_bytes;
  addr_ext_t           addr_inc;
  addr_ext_t           addr_end;
  logic [ADDR_W-1:0]   next_addr;

  // Galois LFSR step, expected read beat and next-burst address arithmetic
  always_comb begin
    seed_eff    = (cfg_seed == 32'd0) ? 32'h1 : cfg_seed;
    lfsr_next   = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : 32'd0);
    exp_rdata   = {NLANE{lfsr}};
    beat_last   = (beat_cnt == len_q);
    write_first = (mode_q != 2'd1);
    start_acc   = (state == ST_IDLE) && cfg_start;
    burst_bytes = addr_ext_t'({1'b0, len_q} + 9'd1) * addr_ext_t'(BEAT_BYTES);
    addr_inc    = {1'b0, addr_q} + burst_bytes;
    addr_end    = addr_inc + burst_bytes;
    // Wrap to the bottom of the window when the following burst would run past it
    next_addr   = (addr_end > {1'b0, STOP_ADDR}) ? START_ADDR : addr_inc[ADDR_W-1:0];
  end

  // Main sequencer: burst issue, write data, response wait, read check
  always_ff @(posedge axi_clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      mode_q         <= '0;
      addr_q         <= '0;
      len_q          <= '0;
      nb_q           <= '0;
      burst_cnt      <= '0;
      lfsr           <= '0;
      lfsr_snap      <= '0;
      beat_cnt       <= '0;
      launch_pending <= 1'b0;
      avalid_q       <= 1'b0;
      atype_q        <= 1'b0;
      wvalid_q       <= 1'b0;
      wlast_q        <= 1'b0;
      bready_q       <= 1'b0;
      rready_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_cnt        <= '0;
      first_err_seen <= 1'b0;
      first_err_addr <= '0;
      first_err_beat <= '0;
      resp_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            mode_q         <= cfg_mode;
            addr_q         <= cfg_base_addr;
            len_q          <= cfg_burst_len;
            nb_q           <= cfg_num_bursts;
            burst_cnt      <= '0;
            lfsr           <= seed_eff;
            lfsr_snap      <= seed_eff;
            err_cnt        <= '0;
            first_err_seen <= 1'b0;
            first_err_addr <= '0;
            first_err_beat <= '0;
            resp_err       <= 1'b0;
            busy_q         <= 1'b1;
            if (cfg_num_bursts == 16'd0) begin
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else if (i_pause) begin
              // Park in NEXT so the first launch waits for the pause to clear
              launch_pending <= 1'b1;
              state          <= ST_NEXT;
            end else begin
              avalid_q <= 1'b1;
              atype_q  <= (cfg_mode != 2'd1);
              state    <= (cfg_mode != 2'd1) ? ST_W_ADDR : ST_R_ADDR;
            end
          end
        end
        ST_W_ADDR: begin
          if (DDR_AREADY_0) begin
            avalid_q <= 1'b0;
            wvalid_q <= 1'b1;
            beat_cnt <= '0;
            wlast_q  <= (len_q == 8'd0);
            state    <= ST_W_DATA;
          end
        end
        ST_W_DATA: begin
          if (DDR_WREADY_0) begin
            lfsr <= lfsr_next;
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state    <= ST_W_RESP;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              wlast_q  <= ((beat_cnt + 8'd1) == len_q);
            end
          end
        end
        ST_W_RESP: begin
          if (DDR_BVALID_0) begin
            bready_q <= 1'b0;
            if (DDR_BRESP_0 != 2'b00 || DDR_BID_0 != '0) resp_err <= 1'b1;
            if (mode_q[1]) begin
              // Replay the pattern of the burst just written
              lfsr     <= lfsr_snap;
              avalid_q <= 1'b1;
              atype_q  <= 1'b0;
              state    <= ST_R_ADDR;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_R_ADDR: begin
          if (DDR_AREADY_0) begin
            avalid_q <= 1'b0;
            rready_q <= 1'b1;
            beat_cnt <= '0;
            state    <= ST_R_DATA;
          end
        end
        ST_R_DATA: begin
          if (DDR_RVALID_0) begin
            lfsr <= lfsr_next;
            if (DDR_RDATA_0 != exp_rdata) begin
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
              if (!first_err_seen) begin
                first_err_seen <= 1'b1;
                first_err_addr <= addr_q;
                first_err_beat <= beat_cnt;
              end
            end
            // Early RLAST or missing RLAST on the final beat are both protocol errors
            if (DDR_RRESP_0 != 2'b00 || DDR_RID_0 != '0 || (DDR_RLAST_0 != beat_last))
              resp_err <= 1'b1;
            if (DDR_RLAST_0) begin
              rready_q <= 1'b0;
              state    <= ST_NEXT;
            end else if (beat_cnt != 8'hFF) begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        ST_NEXT: begin
          if (!i_pause) begin
            if (launch_pending) begin
              launch_pending <= 1'b0;
              lfsr_snap      <= lfsr;
              avalid_q       <= 1'b1;
              atype_q        <= write_first;
              state          <= write_first ? ST_W_ADDR : ST_R_ADDR;
            end else if ((burst_cnt + 16'd1) == nb_q) begin
              burst_cnt <= burst_cnt + 16'd1;
              done_q    <= 1'b1;
              state     <= ST_DONE;
            end else begin
              burst_cnt <= burst_cnt + 16'd1;
              addr_q    <= next_addr;
              lfsr_snap <= lfsr;
              avalid_q  <= 1'b1;
              atype_q   <= write_first;
              state     <= write_first ? ST_W_ADDR : ST_R_ADDR;
            end
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Active-cycle counter: cleared on start, frozen while paused or idle
  always_ff @(posedge axi_clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (start_acc) begin
      cycle_cnt <= '0;
    end else if (busy_q && !i_pause) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  assign DDR_AID_0        = '0;
  assign DDR_AADDR_0      = addr_q;
  assign DDR_ALEN_0       = len_q;
  assign DDR_ASIZE_0      = ASIZE_VAL;
  assign DDR_ABURST_0     = 2'b01;
  assign DDR_ALOCK_0      = 2'b00;
  assign DDR_ATYPE_0      = atype_q;
  assign DDR_AVALID_0     = avalid_q;
  assign DDR_WID_0        = '0;
  assign DDR_WDATA_0      = {NLANE{lfsr}};
  assign DDR_WSTRB_0      = '1;
  assign DDR_WLAST_0      = wlast_q;
  assign DDR_WVALID_0     = wvalid_q;
  assign DDR_RREADY_0     = rready_q;
  assign DDR_BREADY_0     = bready_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_state          = state;
  assign o_err_cnt        = err_cnt;
  assign o_first_err_addr = first_err_addr;
  assign o_first_err_beat = first_err_beat;
  assign o_resp_err       = resp_err;
  assign o_cycle_cnt      = cycle_cnt;

endmodule

// File: tb/tb_axi_traffic_engine.sv
// Directed bench for axi_traffic_engine: a reactive DDR port model that stores
// written beats and echoes them on reads, plus a linear sequence of scenarios
// checked against hand-computed values.
module tb_axi_traffic_engine;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 8;
  localparam int BB     = DATA_W / 8;

  logic                axi_clk = 1'b0;
  logic                rst;
  logic                cfg_start;
  logic [1:0]          cfg_mode;
  logic [ADDR_W-1:0]   cfg_base_addr;
  logic [7:0]          cfg_burst_len;
  logic [15:0]         cfg_num_bursts;
  logic [31:0]         cfg_seed;
  logic                i_pause;
  logic [ID_W-1:0]     DDR_AID_0;
  logic [ADDR_W-1:0]   DDR_AADDR_0;
  logic [7:0]          DDR_ALEN_0;
  logic [2:0]          DDR_ASIZE_0;
  logic [1:0]          DDR_ABURST_0;
  logic [1:0]          DDR_ALOCK_0;
  logic                DDR_ATYPE_0;
  logic                DDR_AVALID_0;
  logic                DDR_AREADY_0;
  logic [ID_W-1:0]     DDR_WID_0;
  logic [DATA_W-1:0]   DDR_WDATA_0;
  logic [DATA_W/8-1:0] DDR_WSTRB_0;
  logic                DDR_WLAST_0;
  logic                DDR_WVALID_0;
  logic                DDR_WREADY_0;
  logic [ID_W-1:0]     DDR_RID_0;
  logic [DATA_W-1:0]   DDR_RDATA_0;
  logic [1:0]          DDR_RRESP_0;
  logic                DDR_RLAST_0;
  logic                DDR_RVALID_0;
  logic                DDR_RREADY_0;
  logic [ID_W-1:0]     DDR_BID_0;
  logic [1:0]          DDR_BRESP_0;
  logic                DDR_BVALID_0;
  logic                DDR_BREADY_0;
  logic                o_busy;
  logic                o_done;
  logic [2:0]          o_state;
  logic [15:0]         o_err_cnt;
  logic [ADDR_W-1:0]   o_first_err_addr;
  logic [7:0]          o_first_err_beat;
  logic                o_resp_err;
  logic [31:0]         o_cycle_cnt;

  axi_traffic_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W),
    .START_ADDR(32'h00000000), .STOP_ADDR(32'h00100000)
  ) dut (
    .axi_clk(axi_clk), .rst(rst), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_base_addr(cfg_base_addr), .cfg_burst_len(cfg_burst_len),
    .cfg_num_bursts(cfg_num_bursts), .cfg_seed(cfg_seed), .i_pause(i_pause),
    .DDR_AID_0(DDR_AID_0), .DDR_AADDR_0(DDR_AADDR_0), .DDR_ALEN_0(DDR_ALEN_0),
    .DDR_ASIZE_0(DDR_ASIZE_0), .DDR_ABURST_0(DDR_ABURST_0), .DDR_ALOCK_0(DDR_ALOCK_0),
    .DDR_ATYPE_0(DDR_ATYPE_0), .DDR_AVALID_0(DDR_AVALID_0), .DDR_AREADY_0(DDR_AREADY_0),
    .DDR_WID_0(DDR_WID_0), .DDR_WDATA_0(DDR_WDATA_0), .DDR_WSTRB_0(DDR_WSTRB_0),
    .DDR_WLAST_0(DDR_WLAST_0), .DDR_WVALID_0(DDR_WVALID_0), .DDR_WREADY_0(DDR_WREADY_0),
    .DDR_RID_0(DDR_RID_0), .DDR_RDATA_0(DDR_RDATA_0), .DDR_RRESP_0(DDR_RRESP_0),
    .DDR_RLAST_0(DDR_RLAST_0), .DDR_RVALID_0(DDR_RVALID_0), .DDR_RREADY_0(DDR_RREADY_0),
    .DDR_BID_0(DDR_BID_0), .DDR_BRESP_0(DDR_BRESP_0), .DDR_BVALID_0(DDR_BVALID_0),
    .DDR_BREADY_0(DDR_BREADY_0), .o_busy(o_busy), .o_done(o_done), .o_state(o_state),
    .o_err_cnt(o_err_cnt), .o_first_err_addr(o_first_err_addr),
    .o_first_err_beat(o_first_err_beat), .o_resp_err(o_resp_err), .o_cycle_cnt(o_cycle_cnt)
  );

  // ---------------- clock / reset block ----------------
  always #5 axi_clk = ~axi_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_miss = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] w_q[$];
  logic              wl_q[$];
  logic [ADDR_W:0]   a_q[$];
  logic [7:0]        alen_q[$];
  logic [DATA_W-1:0] mem [logic [31:0]];

  // responder knobs
  int          wready_mode  = 0;   // 0: always ready, 1: random, 2: never
  int          bdelay       = 0;
  logic        corrupt_en   = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;
  int          corrupt_beat = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- DDR port model ----------------
  // Runs 1ns after each falling edge: reads registered DUT outputs, drives the
  // inputs for the next rising edge and books the handshakes that edge will see.
  initial begin : responder
    int          b_wait;
    bit          b_pend;
    bit          rd_act;
    bit          held_v;
    int          rbeat, rlen, wbeat;
    logic [31:0] rbase, wbase, key;
    logic [DATA_W-1:0] held;
    b_wait = 0; b_pend = 0; rd_act = 0; held_v = 0;
    rbeat = 0; rlen = 0; wbeat = 0; rbase = '0; wbase = '0; held = '0;
    DDR_AREADY_0 = 1'b0; DDR_WREADY_0 = 1'b0; DDR_RID_0 = '0; DDR_RDATA_0 = '0;
    DDR_RRESP_0 = 2'b00; DDR_RLAST_0 = 1'b0; DDR_RVALID_0 = 1'b0;
    DDR_BID_0 = '0; DDR_BRESP_0 = 2'b00; DDR_BVALID_0 = 1'b0;
    forever begin
      @(negedge axi_clk);
      #1;
      if (rst) begin
        b_pend = 0; rd_act = 0; held_v = 0;
        DDR_AREADY_0 = 1'b0; DDR_WREADY_0 = 1'b0;
        DDR_RVALID_0 = 1'b0; DDR_RLAST_0 = 1'b0; DDR_BVALID_0 = 1'b0;
        continue;
      end
      // stalled write beat must be presented unchanged
      if (held_v && DDR_WVALID_0) chk_w("wdata_hold", DDR_WDATA_0, held);
      held_v = 0;
      DDR_AREADY_0 = 1'b1;
      case (wready_mode)
        0:       DDR_WREADY_0 = 1'b1;
        1:       DDR_WREADY_0 = 1'($urandom_range(0, 1));
        default: DDR_WREADY_0 = 1'b0;
      endcase
      DDR_BVALID_0 = 1'b0;
      if (b_pend) begin
        if (b_wait == 0) DDR_BVALID_0 = 1'b1;
        else b_wait--;
      end
      DDR_RVALID_0 = 1'b0; DDR_RLAST_0 = 1'b0; DDR_RDATA_0 = '0;
      if (rd_act) begin
        key = rbase + 32'(rbeat * BB);
        DDR_RVALID_0 = 1'b1;
        DDR_RDATA_0  = mem.exists(key) ? mem[key] : '0;
        if (corrupt_en && rbase == corrupt_addr && rbeat == corrupt_beat)
          DDR_RDATA_0[0] = ~DDR_RDATA_0[0];
        DDR_RLAST_0 = (rbeat == rlen);
      end
      // handshakes taken at the coming rising edge
      if (DDR_AVALID_0 && DDR_AREADY_0) begin
        a_q.push_back({DDR_ATYPE_0, DDR_AADDR_0});
        alen_q.push_back(DDR_ALEN_0);
        if (DDR_ATYPE_0) begin
          wbase = DDR_AADDR_0; wbeat = 0;
        end else begin
          rd_act = 1; rbase = DDR_AADDR_0; rlen = int'(DDR_ALEN_0); rbeat = 0;
        end
      end
      if (DDR_WVALID_0 && DDR_WREADY_0) begin
        mem[wbase + 32'(wbeat * BB)] = DDR_WDATA_0;
        w_q.push_back(DDR_WDATA_0);
        wl_q.push_back(DDR_WLAST_0);
        wbeat++;
        if (DDR_WLAST_0) begin b_pend = 1; b_wait = bdelay; end
      end else if (DDR_WVALID_0) begin
        held = DDR_WDATA_0; held_v = 1;
      end
      if (DDR_BVALID_0 && DDR_BREADY_0) b_pend = 0;
      if (DDR_RVALID_0 && DDR_RREADY_0) begin
        if (DDR_RLAST_0) rd_act = 0;
        else rbeat++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    exp_q.delete(); w_q.delete(); wl_q.delete(); a_q.delete(); alen_q.delete();
  endtask

  task automatic start_run(input logic [1:0] m, input logic [31:0] base, input logic [7:0] len,
                           input logic [15:0] nb, input logic [31:0] seed);
    clear_logs();
    @(negedge axi_clk);
    cfg_mode = m; cfg_base_addr = base; cfg_burst_len = len;
    cfg_num_bursts = nb; cfg_seed = seed; cfg_start = 1'b1;
    @(negedge axi_clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc, output int dones);
    int cyc;
    dones = 0;
    for (cyc = 0; cyc < max_cyc; cyc++) begin
      if (o_done) dones++;
      if (dones > 0 && o_state == 3'd0) break;
      @(negedge axi_clk);
    end
    chk({tag, "_in_time"}, 64'(cyc < max_cyc), 64'd1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int max_cyc);
    for (int i = 0; i < max_cyc && o_state != s; i++) @(negedge axi_clk);
    chk({tag, "_reach"}, 64'(o_state), 64'(s));
  endtask

  function automatic logic [DATA_W-1:0] pop_w();
    return (w_q.size() > 0) ? w_q.pop_front() : '0;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin : stim
    int dones;
    logic [31:0] s1 [8];
    logic [31:0] cyc_snap;
    // LFSR sequence from seed 1 (poly 80200003, shift right)
    s1 = '{32'h00000001, 32'h80200003, 32'hC0300002, 32'h60180001,
           32'hB02C0003, 32'hD8360002, 32'h6C1B0001, 32'hB62D8003};
    rst = 1'b1; cfg_start = 1'b0; cfg_mode = 2'd0; cfg_base_addr = '0;
    cfg_burst_len = '0; cfg_num_bursts = '0; cfg_seed = '0; i_pause = 1'b0;
    repeat (3) @(negedge axi_clk);

    // reset values
    chk("rst_state",  64'(o_state), 64'd0);
    chk("rst_avalid", 64'(DDR_AVALID_0), 64'd0);
    chk("rst_wvalid", 64'(DDR_WVALID_0), 64'd0);
    chk("rst_bready", 64'(DDR_BREADY_0), 64'd0);
    chk("rst_rready", 64'(DDR_RREADY_0), 64'd0);
    chk("rst_busy",   64'(o_busy), 64'd0);
    chk("rst_done",   64'(o_done), 64'd0);
    chk("rst_wstrb",  64'(DDR_WSTRB_0), 64'hFFFF_FFFF);
    chk("rst_asize",  64'(DDR_ASIZE_0), 64'd5);
    chk("rst_aburst", 64'(DDR_ABURST_0), 64'd1);
    chk("rst_cycles", 64'(o_cycle_cnt), 64'd0);
    rst = 1'b0;

    // mode 0, len 3, two bursts from 0, seed 1
    start_run(2'd0, 32'h0, 8'd3, 16'd2, 32'h1);
    wait_done("t1", 200, dones);
    chk("t1_dones",  64'(dones), 64'd1);
    chk("t1_naddr",  64'(a_q.size()), 64'd2);
    chk("t1_addr0",  64'(a_q[0]), {31'd0, 1'b1, 32'h0});
    chk("t1_addr1",  64'(a_q[1]), {31'd0, 1'b1, 32'h80});
    chk("t1_alen",   64'(alen_q[0]), 64'd3);
    chk("t1_nbeats", 64'(w_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) exp_q.push_back({8{s1[i]}});
    for (int i = 0; i < 8; i++) begin
      chk_w("t1_wdata", pop_w(), exp_q.pop_front());
      chk("t1_wlast", 64'(wl_q[i]), 64'((i % 4) == 3));
    end
    chk("t1_cycles", 64'(o_cycle_cnt), 64'd15);
    chk("t1_busy",   64'(o_busy), 64'd0);
    chk("t1_ardd",   64'(DDR_RREADY_0), 64'd0);

    // mode 2 echo, no errors, reads follow each write
    start_run(2'd2, 32'h0, 8'd7, 16'd2, 32'hACE1);
    wait_done("t2", 300, dones);
    chk("t2_dones", 64'(dones), 64'd1);
    chk("t2_err",   64'(o_err_cnt), 64'd0);
    chk("t2_resp",  64'(o_resp_err), 64'd0);
    chk("t2_naddr", 64'(a_q.size()), 64'd4);
    chk("t2_a0", 64'(a_q[0]), {31'd0, 1'b1, 32'h000});
    chk("t2_a1", 64'(a_q[1]), {31'd0, 1'b0, 32'h000});
    chk("t2_a2", 64'(a_q[2]), {31'd0, 1'b1, 32'h100});
    chk("t2_a3", 64'(a_q[3]), {31'd0, 1'b0, 32'h100});

    // mode 2, beat 5 of burst 1 corrupted on read
    corrupt_en = 1'b1; corrupt_addr = 32'h200; corrupt_beat = 5;
    start_run(2'd2, 32'h100, 8'd7, 16'd2, 32'hACE1);
    wait_done("t3", 300, dones);
    corrupt_en = 1'b0;
    chk("t3_err",   64'(o_err_cnt), 64'd1);
    chk("t3_faddr", 64'(o_first_err_addr), 64'h200);
    chk("t3_fbeat", 64'(o_first_err_beat), 64'd5);
    chk("t3_resp",  64'(o_resp_err), 64'd0);

    // random WREADY, late BVALID: beat order and count unchanged
    wready_mode = 1; bdelay = 20;
    start_run(2'd0, 32'h1000, 8'd7, 16'd1, 32'h1);
    wait_done("t4", 400, dones);
    wready_mode = 0; bdelay = 0;
    chk("t4_dones",  64'(dones), 64'd1);
    chk("t4_nbeats", 64'(w_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) exp_q.push_back({8{s1[i]}});
    for (int i = 0; i < 8; i++) begin
      chk_w("t4_wdata", pop_w(), exp_q.pop_front());
      chk("t4_wlast", 64'(wl_q[i]), 64'(i == 7));
    end

    // window wrap, seed 0 replaced by 1
    start_run(2'd0, 32'hFFFC0, 8'd1, 16'd3, 32'h0);
    wait_done("t5", 200, dones);
    chk("t5_naddr", 64'(a_q.size()), 64'd3);
    chk("t5_a0", 64'(a_q[0]), {31'd0, 1'b1, 32'hFFFC0});
    chk("t5_a1", 64'(a_q[1]), {31'd0, 1'b1, 32'h00000});
    chk("t5_a2", 64'(a_q[2]), {31'd0, 1'b1, 32'h00040});
    exp_q.push_back({8{32'h1}});
    exp_q.push_back({8{32'h80200003}});
    chk_w("t5_seed0_b0", pop_w(), exp_q.pop_front());
    chk_w("t5_seed0_b1", pop_w(), exp_q.pop_front());

    // zero bursts: straight to DONE
    start_run(2'd2, 32'h0, 8'd3, 16'd0, 32'h1);
    wait_done("t6", 20, dones);
    chk("t6_dones",  64'(dones), 64'd1);
    chk("t6_naddr",  64'(a_q.size()), 64'd0);
    chk("t6_cycles", 64'(o_cycle_cnt), 64'd1);

    // pause held in NEXT for 10 cycles
    start_run(2'd0, 32'h0, 8'd1, 16'd2, 32'h1);
    wait_state("t7", 3'd6, 50);
    i_pause = 1'b1;
    cyc_snap = o_cycle_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge axi_clk);
      chk("t7_hold_state",  64'(o_state), 64'd6);
      chk("t7_hold_avalid", 64'(DDR_AVALID_0), 64'd0);
    end
    chk("t7_frozen", 64'(o_cycle_cnt), 64'(cyc_snap));
    i_pause = 1'b0;
    wait_done("t7", 100, dones);
    chk("t7_dones",  64'(dones), 64'd1);
    chk("t7_naddr",  64'(a_q.size()), 64'd2);
    chk("t7_cycles", 64'(o_cycle_cnt), 64'd11);

    // reset in the middle of a write burst
    wready_mode = 2;
    start_run(2'd0, 32'h0, 8'd7, 16'd1, 32'h1);
    wait_state("t8", 3'd2, 20);
    rst = 1'b1;
    @(negedge axi_clk);
    chk("t8_state",  64'(o_state), 64'd0);
    chk("t8_wvalid", 64'(DDR_WVALID_0), 64'd0);
    chk("t8_avalid", 64'(DDR_AVALID_0), 64'd0);
    chk("t8_busy",   64'(o_busy), 64'd0);
    rst = 1'b0; wready_mode = 0;

    // single-beat burst after reset
    start_run(2'd0, 32'h40, 8'd0, 16'd1, 32'h5);
    wait_done("t9", 50, dones);
    chk("t9_nbeats", 64'(w_q.size()), 64'd1);
    chk("t9_wlast",  64'(wl_q[0]), 64'd1);
    exp_q.push_back({8{32'h5}});
    chk_w("t9_wdata", pop_w(), exp_q.pop_front());
    chk("t9_addr",   64'(a_q[0]), {31'd0, 1'b1, 32'h40});
    chk("t9_cycles", 64'(o_cycle_cnt), 64'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
